// File: rtl/sn_count.sv
// -----------------------------------------------------------------------------
// sn_count -- stochastic-number-to-binary decoder.
//
// Counts the 1s on a stochastic bitstream over a programmable window of LEN
// qualified samples. The final count, shifted left by OUT_SHIFT, is returned
// on RESULT.
//
// Build option:
//   SN_CNT_BIPOLAR_EN  when defined, the decoder is bipolar. A signed 33-bit
//                      accumulator adds SN_IN_P - SN_IN_N for each sample.
//                      When undefined, SN_IN_N is ignored and the count is
//                      unsigned.
//
// Parameters:
//   OUT_SHIFT  left shift applied to the final count (0..31)
//
// Ports:
//   CLK      clock; all logic on posedge
//   RST      synchronous reset, active-high
//   DATA_IN  write data; [30:0] = window length, [31] ignored
//   LEN_WE   load LEN from DATA_IN[30:0]
//   START    1-cycle strobe: clear counter and begin a window (aborts a run)
//   SN_EN    sample qualifier
//   SN_IN_P  stochastic bit (positive rail)
//   SN_IN_N  negative rail (bipolar build only)
//   BUSY     high while a window is in progress
//   DONE     1-cycle pulse when RESULT updates
//   VALID    high from DONE until the next START or reset
//   RESULT   decoded value
//
// Handshake: a window starts on the cycle after START is sampled high. Each
// cycle in RUN with SN_EN=1 consumes one sample. DONE pulses on the cycle
// after the LEN-th sample, and RESULT/VALID are updated in that same cycle.
// -----------------------------------------------------------------------------
module sn_count #(
   parameter int unsigned OUT_SHIFT = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] DATA_IN,
   input  logic        LEN_WE,
   input  logic        START,
   input  logic        SN_EN,
   input  logic        SN_IN_P,
   input  logic        SN_IN_N,
   output logic        BUSY,
   output logic        DONE,
   output logic        VALID,
   output logic [31:0] RESULT
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [30:0] len_q;
   logic [30:0] remaining_q;
   logic [30:0] eff_len;
   logic        take_sample;
   logic        last_sample;
   logic        done_q, valid_q;
   logic [31:0] result_q;
   logic [31:0] result_val;

`ifdef SN_CNT_BIPOLAR_EN
   // Two's-complement accumulator. P=N contributes zero.
   logic [32:0] count_q, count_sum;
   assign count_sum = count_q + {32'd0, SN_IN_P} - {32'd0, SN_IN_N};
   wire unused_ok = &{1'b0, DATA_IN[31]};
`else
   // LEN is 31 bits wide, so a 32-bit unsigned count can never wrap.
   logic [31:0] count_q, count_sum;
   assign count_sum = count_q + {31'd0, SN_IN_P};
   wire unused_ok = &{1'b0, DATA_IN[31], SN_IN_N};
`endif

   // Sign extension followed by truncation to 32 bits leaves only the low
   // 32 bits of the count, so the shift can work on those bits directly.
   assign result_val = count_sum[31:0] << OUT_SHIFT;

   // A LEN write in the same cycle as START takes effect for that window.
   assign eff_len     = LEN_WE ? DATA_IN[30:0] : len_q;
   assign take_sample = (state_q == S_RUN) && SN_EN;
   assign last_sample = take_sample && (remaining_q == 31'd1);

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (START) begin
         // A zero-length window completes immediately and never enters RUN.
         state_d = (eff_len == 31'd0) ? S_IDLE : S_RUN;
      end else if (last_sample) begin
         state_d = S_IDLE;
      end
   end

   // Datapath
   always_ff @(posedge CLK) begin
      if (RST) begin
         len_q       <= '0;
         remaining_q <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         result_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (LEN_WE) len_q <= DATA_IN[30:0];
         if (START) begin
            // RESULT is kept on START; only VALID drops.
            count_q     <= '0;
            remaining_q <= eff_len;
            valid_q     <= 1'b0;
            if (eff_len == 31'd0) begin
               done_q   <= 1'b1;
               valid_q  <= 1'b1;
               result_q <= '0;
            end
         end else if (take_sample) begin
            count_q     <= count_sum;
            remaining_q <= remaining_q - 31'd1;
            if (remaining_q == 31'd1) begin
               done_q   <= 1'b1;
               valid_q  <= 1'b1;
               result_q <= result_val;
            end
         end
      end
   end

   assign BUSY   = (state_q == S_RUN);
   assign DONE   = done_q;
   assign VALID  = valid_q;
   assign RESULT = result_q;

endmodule

// File: tb/tb_sn_count.sv
// -----------------------------------------------------------------------------
// tb_sn_count -- self-checking bench for sn_count.
//
// Two instances share all inputs: OUT_SHIFT=0 and OUT_SHIFT=29. The reference
// model counts the qualified samples the bench feeds in and sums their
// contributions. After LEN such samples, it expects DONE together with
// RESULT = sum << shift.
// -----------------------------------------------------------------------------
module tb_sn_count;

   // clock / reset
   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST = 1'b1;
   logic [31:0] DATA_IN = '0;
   logic        LEN_WE = 1'b0, START = 1'b0, SN_EN = 1'b0;
   logic        SN_IN_P = 1'b0, SN_IN_N = 1'b0;
   logic        busy0, done0, valid0, busy29, done29, valid29;
   logic [31:0] res0, res29;

   sn_count #(.OUT_SHIFT(0)) dut (
      .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LEN_WE(LEN_WE), .START(START),
      .SN_EN(SN_EN), .SN_IN_P(SN_IN_P), .SN_IN_N(SN_IN_N),
      .BUSY(busy0), .DONE(done0), .VALID(valid0), .RESULT(res0));

   sn_count #(.OUT_SHIFT(29)) dut_s (
      .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LEN_WE(LEN_WE), .START(START),
      .SN_EN(SN_EN), .SN_IN_P(SN_IN_P), .SN_IN_N(SN_IN_N),
      .BUSY(busy29), .DONE(done29), .VALID(valid29), .RESULT(res29));

   // scoreboard
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last0 = '0;
   logic [31:0] last29 = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag, input logic b, input logic d, input logic v);
      chk({tag, "_busy"},    32'(busy0),   32'(b));
      chk({tag, "_done"},    32'(done0),   32'(d));
      chk({tag, "_valid"},   32'(valid0),  32'(v));
      chk({tag, "_busy_s"},  32'(busy29),  32'(b));
      chk({tag, "_done_s"},  32'(done29),  32'(d));
      chk({tag, "_valid_s"}, 32'(valid29), 32'(v));
   endtask

   // driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_len(input int unsigned l);
      DATA_IN = {1'($urandom_range(0, 1)), l[30:0]};
      LEN_WE  = 1'b1;
      tick();
      LEN_WE  = 1'b0;
      DATA_IN = $urandom;
   endtask

   // modes: 0 all ones, 1 alternating 1,0, 2 SN_EN on even offsets,
   // 3 random, 4 bipolar +4/-12 pattern, 5 random with a LEN write mid-run
   task automatic run_window(input int unsigned len, input int mode, input bit load_at_start);
      int unsigned cnt, off;
      int          sum;
      bit          en, pp, nn;
      logic [31:0] e;
      START   = 1'b1;
      SN_EN   = 1'($urandom_range(0, 1));
      SN_IN_P = 1'($urandom_range(0, 1));
      SN_IN_N = 1'($urandom_range(0, 1));
      if (load_at_start) begin
         DATA_IN = {1'($urandom_range(0, 1)), len[30:0]};
         LEN_WE  = 1'b1;
      end
      tick();
      START  = 1'b0;
      LEN_WE = 1'b0;
      if (len == 0) begin
         chk_status("len0", 1'b0, 1'b1, 1'b1);
         chk("len0_result",   res0,  32'd0);
         chk("len0_result_s", res29, 32'd0);
         last0  = '0;
         last29 = '0;
      end else begin
         chk_status("start", 1'b1, 1'b0, 1'b0);
         chk("result_hold",   res0,  last0);
         chk("result_hold_s", res29, last29);
         cnt = 0;
         sum = 0;
         off = 1;
         while (cnt < len && off < 4000) begin
            case (mode)
               0:       begin en = 1'b1; pp = 1'b1; nn = 1'b0; end
               1:       begin en = 1'b1; pp = (cnt % 2 == 0); nn = 1'($urandom_range(0, 1)); end
               2:       begin en = (off % 2 == 0); pp = 1'b1; nn = 1'b0; end
               4:       begin en = 1'b1; pp = (cnt < 4); nn = (cnt >= 4); end
               default: begin
                  en = 1'($urandom_range(0, 1));
                  pp = 1'($urandom_range(0, 1));
                  nn = 1'($urandom_range(0, 1));
               end
            endcase
            SN_EN   = en;
            SN_IN_P = pp;
            SN_IN_N = nn;
            if (mode == 5 && off == 2) begin
               DATA_IN = 32'd2;
               LEN_WE  = 1'b1;
            end
            tick();
            LEN_WE = 1'b0;
            if (en) begin
               cnt++;
`ifdef SN_CNT_BIPOLAR_EN
               sum += int'(pp) - int'(nn);
`else
               sum += int'(pp);
`endif
            end
            if (cnt < len) begin
               chk("run_busy", 32'(busy0), 32'd1);
               chk("run_done", 32'(done0), 32'd0);
            end
            off++;
         end
         if (cnt < len) chk("window_budget", 32'(cnt), 32'(len));
         exp_q.push_back(32'(sum));
         SN_EN = 1'b0;
         chk_status("end", 1'b0, 1'b1, 1'b1);
         e = exp_q.pop_front();
         chk("result",   res0,  e);
         chk("result_s", res29, e << 29);
         last0  = e;
         last29 = e << 29;
      end
      tick();
      chk_status("after", 1'b0, 1'b0, 1'b1);
      chk("result_keep", res0, last0);
   endtask

   // stimulus
   initial begin
      tick();
      tick();
      RST = 1'b0;
      chk_status("reset", 1'b0, 1'b0, 1'b0);
      chk("reset_result",   res0,  32'd0);
      chk("reset_result_s", res29, 32'd0);

      // Full window of ones.
      load_len(8);
      run_window(8, 0, 1'b0);
      // Alternating 1,0 over 16 samples.
      load_len(16);
      run_window(16, 1, 1'b0);
      // SN_EN gating.
      load_len(4);
      run_window(4, 2, 1'b0);
      // Zero-length window.
      load_len(0);
      run_window(0, 0, 1'b0);

      // Abort: START again after 3 samples; only the second window completes.
      load_len(8);
      START = 1'b1;
      tick();
      START   = 1'b0;
      SN_EN   = 1'b1;
      SN_IN_P = 1'b1;
      repeat (3) begin
         tick();
         chk("abort_done", 32'(done0), 32'd0);
         chk("abort_busy", 32'(busy0), 32'd1);
      end
      run_window(8, 0, 1'b0);

      // Shift to the top bit (RESULT = 0x80000000 on the shifted instance).
      load_len(4);
      run_window(4, 0, 1'b0);

      // Reset in mid-run.
      load_len(4);
      START = 1'b1;
      tick();
      START   = 1'b0;
      SN_EN   = 1'b1;
      SN_IN_P = 1'b1;
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk_status("rst_run", 1'b0, 1'b0, 1'b0);
      chk("rst_run_result",   res0,  32'd0);
      chk("rst_run_result_s", res29, 32'd0);
      SN_EN = 1'b0;
      tick();
      chk_status("rst_run_next", 1'b0, 1'b0, 1'b0);
      last0  = '0;
      last29 = '0;
      // The reset must also clear LEN, so this window is zero-length.
      run_window(0, 0, 1'b0);

      // LEN_WE together with START.
      load_len(9);
      run_window(5, 3, 1'b1);
      // A LEN write in mid-run must not alter the running window.
      load_len(6);
      run_window(6, 5, 1'b0);

      // Random windows.
      for (int i = 0; i < 8; i++) begin
         run_window($urandom_range(0, 20), 3, 1'b1);
      end

`ifdef SN_CNT_BIPOLAR_EN
      // +4 then -12 samples: -8.
      load_len(16);
      run_window(16, 4, 1'b0);
      chk("bipolar_result", res0, 32'hFFFF_FFF8);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
